// File: rtl/fifo_memoria_pkg.sv
// fifo_memoria_pkg: shared sizing constants for the FIFO, its memory and the bench
package fifo_memoria_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int BUS_SIZE = 4;
  localparam int MEM_LENGTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(MEM_LENGTH);
endpackage

// File: rtl/fifo_memoria_if.sv
// fifo_memoria_if: push/pop request bus plus data, occupancy and error status
interface fifo_memoria_if;
  import fifo_memoria_pkg::*;
  logic push, pop, valid_out, full, empty, almost_full, almost_empty, overflow_err, underflow_err;
  logic [BUS_SIZE-1:0] data_in, data_out;
  logic [CNT_W-1:0] count;
  modport master (output push, pop, data_in,
                  input data_out, valid_out, count, full, empty, almost_full, almost_empty, overflow_err, underflow_err);
  modport slave (input push, pop, data_in,
                 output data_out, valid_out, count, full, empty, almost_full, almost_empty, overflow_err, underflow_err);
endinterface

// File: rtl/fifo_memoria_memoria_dp.sv
// memoria_dp: dual-port RAM, sync write, registered read that holds when idle; ports clk, reset, read/addressR, write/addressW/data_in, data_out
module memoria_dp
  import fifo_memoria_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addressR,
  input  logic [ADDR_WIDTH-1:0] addressW,
  input  logic [BUS_SIZE-1:0]   data_in,
  output logic [BUS_SIZE-1:0]   data_out
);
  logic [BUS_SIZE-1:0] mem [MEM_LENGTH];
  // The array is deliberately not reset; only the read register is.
  always_ff @(posedge clk)
    if (write) mem[addressW] <= data_in;
  always_ff @(posedge clk or posedge reset)
    if (reset) data_out <= '0;
    else if (read) data_out <= mem[addressR];
endmodule

// File: rtl/fifo_memoria.sv
// fifo_memoria: push/pop FIFO around memoria_dp with count, threshold flags and sticky errors; ports clk, reset, bus (slave)
module fifo_memoria
  import fifo_memoria_pkg::*;
#(
  parameter logic [CNT_W-1:0] ALMOST_FULL_TH = CNT_W'(MEM_LENGTH - 2),
  parameter logic [CNT_W-1:0] ALMOST_EMPTY_TH = CNT_W'(2)
) (
  input logic           clk,
  input logic           reset,
  fifo_memoria_if.slave bus
);
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic valid_q, ovf_q, ovf_d, udf_q, udf_d, push_ok, pop_ok, full, empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    full = count_q == DEPTH;
    empty = count_q == '0;
    push_ok = bus.push & (!full | bus.pop);
    pop_ok = bus.pop & !empty;
    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop_ok);
    count_d = push_ok == pop_ok ? count_q : push_ok ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
    ovf_d = ovf_q | (bus.push & full & !bus.pop);
    udf_d = udf_q | (bus.pop & empty);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      valid_q <= pop_ok;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  memoria_dp u_mem (
    .clk      (clk),
    .reset    (reset),
    .read     (pop_ok),
    .write    (push_ok),
    .addressR (rd_ptr_q),
    .addressW (wr_ptr_q),
    .data_in  (bus.data_in),
    .data_out (bus.data_out)
  );
  assign bus.valid_out = valid_q;
  assign bus.count = count_q;
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = count_q >= ALMOST_FULL_TH;
  assign bus.almost_empty = count_q <= ALMOST_EMPTY_TH;
  assign bus.overflow_err = ovf_q;
  assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_fifo_memoria.sv
// tb_fifo_memoria: directed/random push-pop sequences checked against a queue model of the FIFO
module tb_fifo_memoria;
  import fifo_memoria_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int compared = 0;
  int mismatched = 0;
  logic [BUS_SIZE-1:0] q[$];
  logic [BUS_SIZE-1:0] m_data = '0;
  logic m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  fifo_memoria_if bus ();
  fifo_memoria dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int n = q.size();
    chk("count", 32'(bus.count), n);
    chk("empty", 32'(bus.empty), 32'(n == 0));
    chk("full", 32'(bus.full), 32'(n == MEM_LENGTH));
    chk("almost_full", 32'(bus.almost_full), 32'(n >= MEM_LENGTH - 2));
    chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
    chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
    chk("underflow_err", 32'(bus.underflow_err), 32'(m_udf));
  endtask
  task automatic step(input logic ps, input logic pp, input logic [BUS_SIZE-1:0] d);
    bit was_full, was_empty;
    @(negedge clk);
    bus.push = ps;
    bus.pop = pp;
    bus.data_in = d;
    @(posedge clk);
    was_full = q.size() == MEM_LENGTH;
    was_empty = q.size() == 0;
    m_valid = pp && !was_empty;
    if (m_valid) m_data = q.pop_front();
    if (ps && (!was_full || pp)) q.push_back(d);
    if (ps && was_full && !pp) m_ovf = 1'b1;
    if (pp && was_empty) m_udf = 1'b1;
    #1 check_all();
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    q.delete();
    m_data = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1 check_all();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pushes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, BUS_SIZE'($urandom));
  endtask
  task automatic pops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0);
  endtask
  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    pushes(3);
    do_reset();
    pushes(16);
    pops(16);
    pushes(10);
    pops(10);
    pushes(12);
    pops(12);
    pushes(16);
    step(1'b1, 1'b0, 4'hA);
    step(1'b1, 1'b0, 4'hA);
    pops(16);
    pushes(3);
    step(1'b0, 1'b1, '0);
    do_reset();
    step(1'b1, 1'b1, 4'h5);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b0, '0);
    pushes(16);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, BUS_SIZE'($urandom));
    pops(16);
    do_reset();
    for (int i = 0; i < 400; i++) step(1'($urandom), 1'($urandom), BUS_SIZE'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
